// File: rtl/fp_misc_issue_buffer.sv
// Reservation station for the FP misc/div port: holds micro-ops until both
// sources are woken, issues the oldest ready entry, and drops wrong-path work on redirect.
module fp_misc_issue_buffer #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PAYLOAD_W = 64
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         io_enq_valid,
  output logic                         io_enq_ready,
  input  logic [3:0]                   io_enq_bits_fuType,
  input  logic [6:0]                   io_enq_bits_fuOpType,
  input  logic                         io_enq_bits_srcState_0,
  input  logic                         io_enq_bits_srcState_1,
  input  logic [5:0]                   io_enq_bits_psrc_0,
  input  logic [5:0]                   io_enq_bits_psrc_1,
  input  logic [5:0]                   io_enq_bits_pdest,
  input  logic                         io_enq_bits_robIdx_flag,
  input  logic [4:0]                   io_enq_bits_robIdx_value,
  input  logic [PAYLOAD_W-1:0]         io_enq_bits_payload,
  input  logic                         io_wakeup_0_valid,
  input  logic [5:0]                   io_wakeup_0_pdest,
  input  logic                         io_wakeup_1_valid,
  input  logic [5:0]                   io_wakeup_1_pdest,
  input  logic                         io_redirect_valid,
  input  logic                         io_redirect_robIdx_flag,
  input  logic [4:0]                   io_redirect_robIdx_value,
  output logic                         io_deq_valid,
  input  logic                         io_deq_ready,
  output logic [3:0]                   io_deq_bits_fuType,
  output logic [6:0]                   io_deq_bits_fuOpType,
  output logic [5:0]                   io_deq_bits_psrc_0,
  output logic [5:0]                   io_deq_bits_psrc_1,
  output logic [5:0]                   io_deq_bits_pdest,
  output logic                         io_deq_bits_robIdx_flag,
  output logic [4:0]                   io_deq_bits_robIdx_value,
  output logic [PAYLOAD_W-1:0]         io_deq_bits_payload,
  output logic [$clog2(DEPTH+1)-1:0]   io_count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic [3:0]           fuType;
    logic [6:0]           fuOpType;
    logic [5:0]           psrc0;
    logic [5:0]           psrc1;
    logic [5:0]           pdest;
    logic                 robFlag;
    logic [4:0]           robValue;
    logic [PAYLOAD_W-1:0] payload;
  } entry_t;

  logic [DEPTH-1:0] validQ;
  logic [DEPTH-1:0] src0Q;
  logic [DEPTH-1:0] src1Q;
  entry_t           entryQ [DEPTH];
  logic [DEPTH-1:0] ageQ   [DEPTH];

  logic [DEPTH-1:0] wake0;
  logic [DEPTH-1:0] wake1;
  logic [DEPTH-1:0] flush;
  logic [DEPTH-1:0] readyVec;
  logic [DEPTH-1:0] sel;
  logic [IDX_W-1:0] selIdx;
  logic [IDX_W-1:0] freeIdx;
  logic             hasFree;
  logic             enqWake0;
  logic             enqWake1;
  logic             enqFire;
  logic             deqFire;
  logic [CNT_W-1:0] cnt;

  // Wakeup match, redirect flush and readiness per entry
  always_comb begin
    wake0    = '0;
    wake1    = '0;
    flush    = '0;
    readyVec = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      wake0[i] = (io_wakeup_0_valid && io_wakeup_0_pdest == entryQ[i].psrc0) ||
                 (io_wakeup_1_valid && io_wakeup_1_pdest == entryQ[i].psrc0);
      wake1[i] = (io_wakeup_0_valid && io_wakeup_0_pdest == entryQ[i].psrc1) ||
                 (io_wakeup_1_valid && io_wakeup_1_pdest == entryQ[i].psrc1);
      flush[i] = io_redirect_valid &&
                 ((entryQ[i].robFlag ^ io_redirect_robIdx_flag) ^
                  (entryQ[i].robValue > io_redirect_robIdx_value));
      readyVec[i] = validQ[i] && src0Q[i] && src1Q[i] && !flush[i];
    end
  end

  // Oldest-ready select: an entry wins when it is older than every other ready entry
  always_comb begin
    sel    = '0;
    selIdx = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      sel[i] = readyVec[i];
      for (int j = 0; j < int'(DEPTH); j++) begin
        if (j != i && readyVec[j] && !ageQ[i][j]) sel[i] = 1'b0;
      end
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (sel[i]) selIdx = IDX_W'(i);
    end
  end

  // Lowest-index free slot
  always_comb begin
    freeIdx = '0;
    hasFree = ~(&validQ);
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      if (!validQ[i]) freeIdx = IDX_W'(i);
    end
  end

  assign enqWake0 = (io_wakeup_0_valid && io_wakeup_0_pdest == io_enq_bits_psrc_0) ||
                    (io_wakeup_1_valid && io_wakeup_1_pdest == io_enq_bits_psrc_0);
  assign enqWake1 = (io_wakeup_0_valid && io_wakeup_0_pdest == io_enq_bits_psrc_1) ||
                    (io_wakeup_1_valid && io_wakeup_1_pdest == io_enq_bits_psrc_1);

  assign io_enq_ready = hasFree && !io_redirect_valid;
  assign enqFire      = io_enq_valid && io_enq_ready;
  assign io_deq_valid = |readyVec;
  assign deqFire      = io_deq_valid && io_deq_ready;

  // Entry state, wakeups, issue/flush retirement and age matrix update
  always_ff @(posedge clock) begin
    if (reset) begin
      validQ <= '0;
      src0Q  <= '0;
      src1Q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) ageQ[i] <= '0;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (flush[i] || (deqFire && sel[i])) validQ[i] <= 1'b0;
        if (wake0[i]) src0Q[i] <= 1'b1;
        if (wake1[i]) src1Q[i] <= 1'b1;
      end
      if (enqFire) begin
        validQ[freeIdx] <= 1'b1;
        src0Q[freeIdx]  <= io_enq_bits_srcState_0 | enqWake0;
        src1Q[freeIdx]  <= io_enq_bits_srcState_1 | enqWake1;
        ageQ[freeIdx]   <= '0;
        for (int j = 0; j < int'(DEPTH); j++) begin
          if (validQ[j]) ageQ[j][freeIdx] <= 1'b1;
        end
      end
    end
  end

  // Payload storage needs no reset; it is qualified by validQ
  always_ff @(posedge clock) begin
    if (enqFire) begin
      entryQ[freeIdx] <= '{fuType:   io_enq_bits_fuType,
                           fuOpType: io_enq_bits_fuOpType,
                           psrc0:    io_enq_bits_psrc_0,
                           psrc1:    io_enq_bits_psrc_1,
                           pdest:    io_enq_bits_pdest,
                           robFlag:  io_enq_bits_robIdx_flag,
                           robValue: io_enq_bits_robIdx_value,
                           payload:  io_enq_bits_payload};
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < int'(DEPTH); i++) cnt = cnt + CNT_W'(validQ[i]);
  end

  assign io_count                 = cnt;
  assign io_deq_bits_fuType       = entryQ[selIdx].fuType;
  assign io_deq_bits_fuOpType     = entryQ[selIdx].fuOpType;
  assign io_deq_bits_psrc_0       = entryQ[selIdx].psrc0;
  assign io_deq_bits_psrc_1       = entryQ[selIdx].psrc1;
  assign io_deq_bits_pdest        = entryQ[selIdx].pdest;
  assign io_deq_bits_robIdx_flag  = entryQ[selIdx].robFlag;
  assign io_deq_bits_robIdx_value = entryQ[selIdx].robValue;
  assign io_deq_bits_payload      = entryQ[selIdx].payload;

endmodule

// File: tb/tb_fp_misc_issue_buffer.sv
// Bench for fp_misc_issue_buffer: vector table for dispatch-time wakeup capture,
// hand sequences for ordering, redirect and reset, and an issue scoreboard.
module tb_fp_misc_issue_buffer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        io_enq_valid = 1'b0;
  logic        io_enq_ready;
  logic [3:0]  io_enq_bits_fuType = '0;
  logic [6:0]  io_enq_bits_fuOpType = '0;
  logic        io_enq_bits_srcState_0 = 1'b0;
  logic        io_enq_bits_srcState_1 = 1'b0;
  logic [5:0]  io_enq_bits_psrc_0 = '0;
  logic [5:0]  io_enq_bits_psrc_1 = '0;
  logic [5:0]  io_enq_bits_pdest = '0;
  logic        io_enq_bits_robIdx_flag = 1'b0;
  logic [4:0]  io_enq_bits_robIdx_value = '0;
  logic [63:0] io_enq_bits_payload = '0;
  logic        io_wakeup_0_valid = 1'b0;
  logic [5:0]  io_wakeup_0_pdest = '0;
  logic        io_wakeup_1_valid = 1'b0;
  logic [5:0]  io_wakeup_1_pdest = '0;
  logic        io_redirect_valid = 1'b0;
  logic        io_redirect_robIdx_flag = 1'b0;
  logic [4:0]  io_redirect_robIdx_value = '0;
  logic        io_deq_valid;
  logic        io_deq_ready = 1'b0;
  logic [3:0]  io_deq_bits_fuType;
  logic [6:0]  io_deq_bits_fuOpType;
  logic [5:0]  io_deq_bits_psrc_0;
  logic [5:0]  io_deq_bits_psrc_1;
  logic [5:0]  io_deq_bits_pdest;
  logic        io_deq_bits_robIdx_flag;
  logic [4:0]  io_deq_bits_robIdx_value;
  logic [63:0] io_deq_bits_payload;
  logic [2:0]  io_count;

  fp_misc_issue_buffer #(.DEPTH(4), .PAYLOAD_W(64)) dut (
    .clock(clock), .reset(reset),
    .io_enq_valid(io_enq_valid), .io_enq_ready(io_enq_ready),
    .io_enq_bits_fuType(io_enq_bits_fuType), .io_enq_bits_fuOpType(io_enq_bits_fuOpType),
    .io_enq_bits_srcState_0(io_enq_bits_srcState_0), .io_enq_bits_srcState_1(io_enq_bits_srcState_1),
    .io_enq_bits_psrc_0(io_enq_bits_psrc_0), .io_enq_bits_psrc_1(io_enq_bits_psrc_1),
    .io_enq_bits_pdest(io_enq_bits_pdest),
    .io_enq_bits_robIdx_flag(io_enq_bits_robIdx_flag), .io_enq_bits_robIdx_value(io_enq_bits_robIdx_value),
    .io_enq_bits_payload(io_enq_bits_payload),
    .io_wakeup_0_valid(io_wakeup_0_valid), .io_wakeup_0_pdest(io_wakeup_0_pdest),
    .io_wakeup_1_valid(io_wakeup_1_valid), .io_wakeup_1_pdest(io_wakeup_1_pdest),
    .io_redirect_valid(io_redirect_valid), .io_redirect_robIdx_flag(io_redirect_robIdx_flag),
    .io_redirect_robIdx_value(io_redirect_robIdx_value),
    .io_deq_valid(io_deq_valid), .io_deq_ready(io_deq_ready),
    .io_deq_bits_fuType(io_deq_bits_fuType), .io_deq_bits_fuOpType(io_deq_bits_fuOpType),
    .io_deq_bits_psrc_0(io_deq_bits_psrc_0), .io_deq_bits_psrc_1(io_deq_bits_psrc_1),
    .io_deq_bits_pdest(io_deq_bits_pdest),
    .io_deq_bits_robIdx_flag(io_deq_bits_robIdx_flag), .io_deq_bits_robIdx_value(io_deq_bits_robIdx_value),
    .io_deq_bits_payload(io_deq_bits_payload),
    .io_count(io_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [5:0] pdest;
    logic       flag;
    logic [4:0] value;
    logic [5:0] p0;
    logic [5:0] p1;
  } exp_t;

  typedef struct {
    logic       s0;
    logic       s1;
    logic [5:0] p0;
    logic [5:0] p1;
    logic       w0v;
    logic [5:0] w0p;
    logic       w1v;
    logic [5:0] w1p;
    logic       expReady;
  } vec_t;

  exp_t sbq[$];
  int   checks = 0;
  int   failures = 0;

  function automatic logic [63:0] payloadOf(input logic [5:0] pd);
    return {32'hCAFEF00D, 26'h0, pd};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pushExp(input logic [5:0] pd, input logic fl, input logic [4:0] v,
                         input logic [5:0] p0, input logic [5:0] p1);
    exp_t e;
    e.pdest = pd; e.flag = fl; e.value = v; e.p0 = p0; e.p1 = p1;
    sbq.push_back(e);
  endtask

  task automatic enq(input logic s0, input logic s1, input logic [5:0] p0, input logic [5:0] p1,
                     input logic [5:0] pd, input logic fl, input logic [4:0] v);
    io_enq_valid = 1'b1;
    io_enq_bits_srcState_0 = s0;
    io_enq_bits_srcState_1 = s1;
    io_enq_bits_psrc_0 = p0;
    io_enq_bits_psrc_1 = p1;
    io_enq_bits_pdest = pd;
    io_enq_bits_fuType = pd[3:0];
    io_enq_bits_fuOpType = {1'b1, pd};
    io_enq_bits_robIdx_flag = fl;
    io_enq_bits_robIdx_value = v;
    io_enq_bits_payload = payloadOf(pd);
    #1;
    check("enq_ready_before_enq", 64'(io_enq_ready), 64'd1);
    tick();
    io_enq_valid = 1'b0;
  endtask

  task automatic wake(input logic v0, input logic [5:0] d0, input logic v1, input logic [5:0] d1);
    io_wakeup_0_valid = v0; io_wakeup_0_pdest = d0;
    io_wakeup_1_valid = v1; io_wakeup_1_pdest = d1;
    tick();
    io_wakeup_0_valid = 1'b0;
    io_wakeup_1_valid = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (sbq.size() != 0 && n < budget);
    if (sbq.size() != 0) begin
      check("drain_timeout_pending", 64'(sbq.size()), 64'd0);
      sbq.delete();
    end
  endtask

  // Issue monitor: every fired deq must match the head of the scoreboard
  always @(negedge clock) begin
    if (!reset && io_deq_valid && io_deq_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_issue actual_pdest=%0d required=none", io_deq_bits_pdest);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("deq_bits",
              64'({io_deq_bits_fuType, io_deq_bits_fuOpType, io_deq_bits_psrc_0, io_deq_bits_psrc_1,
                   io_deq_bits_pdest, io_deq_bits_robIdx_flag, io_deq_bits_robIdx_value}),
              64'({e.pdest[3:0], 1'b1, e.pdest, e.p0, e.p1, e.pdest, e.flag, e.value}));
        check("deq_payload", io_deq_bits_payload, payloadOf(e.pdest));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    tbl[0] = '{s0:1'b0, s1:1'b1, p0:6'd9,  p1:6'd0,  w0v:1'b1, w0p:6'd9,  w1v:1'b0, w1p:6'd0,  expReady:1'b1};
    tbl[1] = '{s0:1'b1, s1:1'b0, p0:6'd0,  p1:6'd33, w0v:1'b0, w0p:6'd0,  w1v:1'b1, w1p:6'd33, expReady:1'b1};
    tbl[2] = '{s0:1'b0, s1:1'b0, p0:6'd40, p1:6'd41, w0v:1'b1, w0p:6'd40, w1v:1'b1, w1p:6'd41, expReady:1'b1};
    tbl[3] = '{s0:1'b0, s1:1'b0, p0:6'd42, p1:6'd42, w0v:1'b1, w0p:6'd42, w1v:1'b0, w1p:6'd0,  expReady:1'b1};
    tbl[4] = '{s0:1'b0, s1:1'b1, p0:6'd43, p1:6'd0,  w0v:1'b1, w0p:6'd44, w1v:1'b0, w1p:6'd0,  expReady:1'b0};
    tbl[5] = '{s0:1'b0, s1:1'b1, p0:6'd45, p1:6'd0,  w0v:1'b0, w0p:6'd45, w1v:1'b0, w1p:6'd0,  expReady:1'b0};
    tbl[6] = '{s0:1'b1, s1:1'b1, p0:6'd46, p1:6'd47, w0v:1'b0, w0p:6'd0,  w1v:1'b0, w1p:6'd0,  expReady:1'b1};

    repeat (3) tick();
    reset = 1'b0;
    check("reset_deq_valid", 64'(io_deq_valid), 64'd0);
    check("reset_count", 64'(io_count), 64'd0);
    check("reset_enq_ready", 64'(io_enq_ready), 64'd1);

    // Single ready entry issues the cycle after enqueue
    io_deq_ready = 1'b1;
    pushExp(6'd1, 1'b0, 5'd3, 6'd2, 6'd3);
    enq(1'b1, 1'b1, 6'd2, 6'd3, 6'd1, 1'b0, 5'd3);
    check("a_deq_valid", 64'(io_deq_valid), 64'd1);
    check("a_deq_rob", 64'(io_deq_bits_robIdx_value), 64'd3);
    tick();
    check("a_count_after_issue", 64'(io_count), 64'd0);

    // Dispatch-time wakeup capture table
    for (int k = 0; k < 7; k++) begin
      if (tbl[k].expReady) pushExp(6'(24 + k), 1'b0, 5'(k), tbl[k].p0, tbl[k].p1);
      io_wakeup_0_valid = tbl[k].w0v; io_wakeup_0_pdest = tbl[k].w0p;
      io_wakeup_1_valid = tbl[k].w1v; io_wakeup_1_pdest = tbl[k].w1p;
      enq(tbl[k].s0, tbl[k].s1, tbl[k].p0, tbl[k].p1, 6'(24 + k), 1'b0, 5'(k));
      io_wakeup_0_valid = 1'b0;
      io_wakeup_1_valid = 1'b0;
      check($sformatf("vec%0d_ready_next_cycle", k), 64'(io_deq_valid), 64'(tbl[k].expReady));
      if (!tbl[k].expReady) begin
        pushExp(6'(24 + k), 1'b0, 5'(k), tbl[k].p0, tbl[k].p1);
        wake(1'b1, tbl[k].p0, 1'b1, tbl[k].p1);
      end
      waitDrain(10);
      check($sformatf("vec%0d_count_empty", k), 64'(io_count), 64'd0);
    end

    // Fill, then wake only entry 2
    for (int i = 0; i < 4; i++)
      enq(1'b0, 1'b0, 6'(8 + 2 * i), 6'(9 + 2 * i), 6'(48 + i), 1'b0, 5'(10 + i));
    check("full_enq_ready", 64'(io_enq_ready), 64'd0);
    check("full_count", 64'(io_count), 64'd4);
    check("full_deq_valid", 64'(io_deq_valid), 64'd0);
    pushExp(6'd50, 1'b0, 5'd12, 6'd12, 6'd13);
    wake(1'b1, 6'd12, 1'b0, 6'd0);
    check("half_woken_deq_valid", 64'(io_deq_valid), 64'd0);
    wake(1'b1, 6'd13, 1'b0, 6'd0);
    check("e2_deq_valid", 64'(io_deq_valid), 64'd1);
    tick();
    check("e2_enq_ready_after", 64'(io_enq_ready), 64'd1);
    check("e2_count_after", 64'(io_count), 64'd3);
    pushExp(6'd48, 1'b0, 5'd10, 6'd8, 6'd9);
    pushExp(6'd49, 1'b0, 5'd11, 6'd10, 6'd11);
    pushExp(6'd51, 1'b0, 5'd13, 6'd14, 6'd15);
    wake(1'b1, 6'd8, 1'b1, 6'd9);
    wake(1'b1, 6'd10, 1'b1, 6'd11);
    wake(1'b1, 6'd14, 1'b1, 6'd15);
    waitDrain(10);
    check("fill_count_empty", 64'(io_count), 64'd0);

    // Simultaneously ready: older wins, bits stable while stalled
    io_deq_ready = 1'b0;
    enq(1'b0, 1'b0, 6'd20, 6'd20, 6'd21, 1'b0, 5'd21);
    enq(1'b0, 1'b0, 6'd20, 6'd20, 6'd22, 1'b0, 5'd22);
    pushExp(6'd21, 1'b0, 5'd21, 6'd20, 6'd20);
    pushExp(6'd22, 1'b0, 5'd22, 6'd20, 6'd20);
    wake(1'b1, 6'd20, 1'b0, 6'd0);
    check("bc_deq_valid", 64'(io_deq_valid), 64'd1);
    check("bc_oldest_sel", 64'(io_deq_bits_pdest), 64'd21);
    tick();
    check("bc_stall_stable", 64'(io_deq_bits_pdest), 64'd21);
    io_deq_ready = 1'b1;
    waitDrain(10);
    check("bc_count_empty", 64'(io_count), 64'd0);

    // Redirect with wraparound compare; enqueue blocked during redirect
    io_deq_ready = 1'b0;
    enq(1'b0, 1'b0, 6'd52, 6'd53, 6'd56, 1'b0, 5'd30);
    enq(1'b0, 1'b0, 6'd54, 6'd55, 6'd57, 1'b1, 5'd2);
    enq(1'b0, 1'b0, 6'd58, 6'd59, 6'd58, 1'b1, 5'd5);
    check("rd_count_before", 64'(io_count), 64'd3);
    io_redirect_valid = 1'b1;
    io_redirect_robIdx_flag = 1'b1;
    io_redirect_robIdx_value = 5'd2;
    io_enq_valid = 1'b1;
    io_enq_bits_srcState_0 = 1'b1;
    io_enq_bits_srcState_1 = 1'b1;
    io_enq_bits_pdest = 6'd61;
    #1;
    check("rd_enq_ready", 64'(io_enq_ready), 64'd0);
    tick();
    io_redirect_valid = 1'b0;
    io_enq_valid = 1'b0;
    check("rd_count_after", 64'(io_count), 64'd2);
    pushExp(6'd56, 1'b0, 5'd30, 6'd52, 6'd53);
    pushExp(6'd57, 1'b1, 5'd2, 6'd54, 6'd55);
    io_deq_ready = 1'b1;
    wake(1'b1, 6'd52, 1'b1, 6'd53);
    wake(1'b1, 6'd54, 1'b1, 6'd55);
    wake(1'b1, 6'd58, 1'b1, 6'd59);
    waitDrain(10);
    tick();
    check("rd_count_empty", 64'(io_count), 64'd0);
    check("rd_flushed_not_issued", 64'(io_deq_valid), 64'd0);

    // Ready entry flushed in the cycle it would issue
    io_deq_ready = 1'b0;
    enq(1'b1, 1'b1, 6'd1, 6'd2, 6'd60, 1'b1, 5'd7);
    check("fi_ready_before", 64'(io_deq_valid), 64'd1);
    io_redirect_valid = 1'b1;
    io_redirect_robIdx_flag = 1'b1;
    io_redirect_robIdx_value = 5'd6;
    io_deq_ready = 1'b1;
    #1;
    check("fi_masked", 64'(io_deq_valid), 64'd0);
    tick();
    io_redirect_valid = 1'b0;
    check("fi_count", 64'(io_count), 64'd0);

    // Reset mid-operation
    io_deq_ready = 1'b0;
    enq(1'b0, 1'b0, 6'd30, 6'd31, 6'd32, 1'b0, 5'd1);
    enq(1'b1, 1'b1, 6'd30, 6'd31, 6'd33, 1'b0, 5'd2);
    enq(1'b0, 1'b1, 6'd30, 6'd31, 6'd34, 1'b0, 5'd3);
    check("mr_count", 64'(io_count), 64'd3);
    check("mr_deq_valid", 64'(io_deq_valid), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mr_deq_valid_after", 64'(io_deq_valid), 64'd0);
    check("mr_count_after", 64'(io_count), 64'd0);
    check("mr_enq_ready_after", 64'(io_enq_ready), 64'd1);
    check("sb_empty_at_end", 64'(sbq.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
